// File: rtl/rv32i_types.sv
// Shared RV32I encodings and bundle headers for the register-file scoreboard.
package rv32i_types;

  localparam int NUM_REGS = 32;

  typedef logic [4:0] reg_idx_t;
  typedef logic [6:0] opcode_t;

  localparam opcode_t store_opcode = 7'b0100011;
  localparam opcode_t br_opcode    = 7'b1100011;

  typedef struct packed {
    logic     we;
    reg_idx_t rd;
  } commit_hdr_t;

  typedef struct packed {
    logic     valid;
    opcode_t  opcode;
    reg_idx_t rd;
  } issue_hdr_t;

  // Stores and branches carry an rd field that is really immediate bits.
  function automatic logic is_writer(issue_hdr_t h);
    return h.valid && (h.rd != '0) && (h.opcode != store_opcode) && (h.opcode != br_opcode);
  endfunction

endpackage

// File: rtl/sb_src_resolve.sv
// Resolves one source operand of issue slot SLOT against older same-cycle
// writers, same-cycle commits and the registered scoreboard state.
module sb_src_resolve
  import rv32i_types::*;
#(
  parameter int SLOT       = 0,
  parameter int NUM_ISSUE  = 2,
  parameter int NUM_COMMIT = 2,
  parameter int ROB_IDX_W  = 4,
  parameter int XLEN       = 32
) (
  input  logic [4:0]                           rs,
  input  logic [NUM_ISSUE-1:0]                 writer,
  input  logic [NUM_ISSUE-1:0][4:0]            issue_rd,
  input  logic [NUM_ISSUE-1:0][ROB_IDX_W-1:0]  issue_rob,
  input  logic [NUM_COMMIT-1:0]                commit_we,
  input  logic [NUM_COMMIT-1:0][4:0]           commit_rd,
  input  logic [NUM_COMMIT-1:0][ROB_IDX_W-1:0] commit_rob,
  input  logic [NUM_COMMIT-1:0][XLEN-1:0]      commit_v,
  input  logic                                 sb_valid,
  input  logic [ROB_IDX_W-1:0]                 sb_tag,
  input  logic [XLEN-1:0]                      reg_val,
  output logic [XLEN-1:0]                      v,
  output logic                                 ready,
  output logic [ROB_IDX_W-1:0]                 rob
);

  logic                 hit_issue;
  logic [ROB_IDX_W-1:0] issue_tag;
  logic                 hit_commit;
  logic [XLEN-1:0]      commit_val;

  always_comb begin
    hit_issue  = 1'b0;
    issue_tag  = '0;
    hit_commit = 1'b0;
    commit_val = '0;
    // Later iterations overwrite earlier ones, so the youngest match wins.
    for (int j = 0; j < NUM_ISSUE; j++) begin
      if ((j < SLOT) && writer[j] && (issue_rd[j] == rs)) begin
        hit_issue = 1'b1;
        issue_tag = issue_rob[j];
      end
    end
    for (int p = 0; p < NUM_COMMIT; p++) begin
      if (commit_we[p] && (commit_rd[p] == rs) && (commit_rob[p] == sb_tag)) begin
        hit_commit = 1'b1;
        commit_val = commit_v[p];
      end
    end

    v     = '0;
    ready = 1'b1;
    rob   = '0;
    if (rs == '0) begin
      ready = 1'b1;
    end else if (hit_issue) begin
      ready = 1'b0;
      rob   = issue_tag;
    end else if (sb_valid && hit_commit) begin
      v = commit_val;
    end else if (sb_valid) begin
      ready = 1'b0;
      rob   = sb_tag;
    end else begin
      v = reg_val;
    end
  end

endmodule

// File: rtl/regfile_scoreboard_ss.sv
// Superscalar register file with a per-register pending-writer scoreboard
// and same-cycle issue/commit operand resolution.
module regfile_scoreboard_ss
  import rv32i_types::*;
#(
  parameter int NUM_ISSUE  = 2,
  parameter int NUM_COMMIT = 2,
  parameter int ROB_IDX_W  = 4,
  parameter int XLEN       = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 flush,
  input  logic [NUM_COMMIT-1:0]                commit_we,
  input  logic [NUM_COMMIT-1:0][4:0]           commit_rd_s,
  input  logic [NUM_COMMIT-1:0][XLEN-1:0]      commit_rd_v,
  input  logic [NUM_COMMIT-1:0][ROB_IDX_W-1:0] commit_rob,
  input  logic [NUM_ISSUE-1:0]                 issue_valid,
  input  logic [NUM_ISSUE-1:0][6:0]            issue_opcode,
  input  logic [NUM_ISSUE-1:0][4:0]            issue_rd_s,
  input  logic [NUM_ISSUE-1:0][ROB_IDX_W-1:0]  issue_rob,
  input  logic [NUM_ISSUE-1:0][4:0]            issue_rs1_s,
  input  logic [NUM_ISSUE-1:0][4:0]            issue_rs2_s,
  output logic [NUM_ISSUE-1:0][XLEN-1:0]       issue_rs1_v,
  output logic [NUM_ISSUE-1:0][XLEN-1:0]       issue_rs2_v,
  output logic [NUM_ISSUE-1:0]                 issue_rs1_ready,
  output logic [NUM_ISSUE-1:0]                 issue_rs2_ready,
  output logic [NUM_ISSUE-1:0][ROB_IDX_W-1:0]  issue_rs1_rob,
  output logic [NUM_ISSUE-1:0][ROB_IDX_W-1:0]  issue_rs2_rob,
  output logic [5:0]                           sb_busy_cnt
);

  logic [NUM_REGS-1:0][XLEN-1:0]      regs;
  logic [NUM_REGS-1:0]                sb_valid, valid_nxt;
  logic [NUM_REGS-1:0][ROB_IDX_W-1:0] sb_tag, tag_nxt;
  logic [NUM_ISSUE-1:0]               writer;
  commit_hdr_t [NUM_COMMIT-1:0]       cmt;
  issue_hdr_t                         hdr;
  logic [5:0]                         busy_nxt;

  always_comb begin
    writer = '0;
    hdr    = '0;
    for (int s = 0; s < NUM_ISSUE; s++) begin
      hdr.valid  = issue_valid[s];
      hdr.opcode = issue_opcode[s];
      hdr.rd     = issue_rd_s[s];
      writer[s]  = is_writer(hdr);
    end
    cmt = '0;
    for (int p = 0; p < NUM_COMMIT; p++) begin
      cmt[p].we = commit_we[p];
      cmt[p].rd = commit_rd_s[p];
    end
  end

  // Clears use the registered state; issue sets land after them so they win.
  always_comb begin
    valid_nxt = sb_valid;
    tag_nxt   = sb_tag;
    for (int p = 0; p < NUM_COMMIT; p++) begin
      if (cmt[p].we && (cmt[p].rd != '0) && sb_valid[cmt[p].rd] &&
          (commit_rob[p] == sb_tag[cmt[p].rd])) begin
        valid_nxt[cmt[p].rd] = 1'b0;
      end
    end
    for (int s = 0; s < NUM_ISSUE; s++) begin
      if (writer[s]) begin
        valid_nxt[issue_rd_s[s]] = 1'b1;
        tag_nxt[issue_rd_s[s]]   = issue_rob[s];
      end
    end
    if (flush) begin
      valid_nxt = '0;
      tag_nxt   = '0;
    end
    valid_nxt[0] = 1'b0;
    tag_nxt[0]   = '0;
    busy_nxt = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_nxt = busy_nxt + {5'b0, valid_nxt[r]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs        <= '0;
      sb_valid    <= '0;
      sb_tag      <= '0;
      sb_busy_cnt <= '0;
    end else begin
      sb_valid    <= valid_nxt;
      sb_tag      <= tag_nxt;
      sb_busy_cnt <= busy_nxt;
      for (int p = 0; p < NUM_COMMIT; p++) begin
        if (commit_we[p] && (commit_rd_s[p] != '0)) begin
          regs[commit_rd_s[p]] <= commit_rd_v[p];
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_ISSUE; k++) begin : g_slot
    sb_src_resolve #(
      .SLOT(k), .NUM_ISSUE(NUM_ISSUE), .NUM_COMMIT(NUM_COMMIT),
      .ROB_IDX_W(ROB_IDX_W), .XLEN(XLEN)
    ) u_rs1 (
      .rs(issue_rs1_s[k]), .writer(writer), .issue_rd(issue_rd_s), .issue_rob(issue_rob),
      .commit_we(commit_we), .commit_rd(commit_rd_s), .commit_rob(commit_rob),
      .commit_v(commit_rd_v), .sb_valid(sb_valid[issue_rs1_s[k]]),
      .sb_tag(sb_tag[issue_rs1_s[k]]), .reg_val(regs[issue_rs1_s[k]]),
      .v(issue_rs1_v[k]), .ready(issue_rs1_ready[k]), .rob(issue_rs1_rob[k])
    );
    sb_src_resolve #(
      .SLOT(k), .NUM_ISSUE(NUM_ISSUE), .NUM_COMMIT(NUM_COMMIT),
      .ROB_IDX_W(ROB_IDX_W), .XLEN(XLEN)
    ) u_rs2 (
      .rs(issue_rs2_s[k]), .writer(writer), .issue_rd(issue_rd_s), .issue_rob(issue_rob),
      .commit_we(commit_we), .commit_rd(commit_rd_s), .commit_rob(commit_rob),
      .commit_v(commit_rd_v), .sb_valid(sb_valid[issue_rs2_s[k]]),
      .sb_tag(sb_tag[issue_rs2_s[k]]), .reg_val(regs[issue_rs2_s[k]]),
      .v(issue_rs2_v[k]), .ready(issue_rs2_ready[k]), .rob(issue_rs2_rob[k])
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard_ss.sv
// Directed bench for regfile_scoreboard_ss: stimulus queues expected operand
// results, a monitor compares them against the DUT away from the clock edge.
module tb_regfile_scoreboard_ss;

  localparam int NI = 2;
  localparam int NC = 2;
  localparam int RW = 4;
  localparam int XL = 32;
  localparam logic [6:0] OP_ALU = 7'b0110011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     flush;
  logic [NC-1:0]            commit_we;
  logic [NC-1:0][4:0]       commit_rd_s;
  logic [NC-1:0][XL-1:0]    commit_rd_v;
  logic [NC-1:0][RW-1:0]    commit_rob;
  logic [NI-1:0]            issue_valid;
  logic [NI-1:0][6:0]       issue_opcode;
  logic [NI-1:0][4:0]       issue_rd_s;
  logic [NI-1:0][RW-1:0]    issue_rob;
  logic [NI-1:0][4:0]       issue_rs1_s;
  logic [NI-1:0][4:0]       issue_rs2_s;
  logic [NI-1:0][XL-1:0]    issue_rs1_v;
  logic [NI-1:0][XL-1:0]    issue_rs2_v;
  logic [NI-1:0]            issue_rs1_ready;
  logic [NI-1:0]            issue_rs2_ready;
  logic [NI-1:0][RW-1:0]    issue_rs1_rob;
  logic [NI-1:0][RW-1:0]    issue_rs2_rob;
  logic [5:0]               sb_busy_cnt;

  regfile_scoreboard_ss #(
    .NUM_ISSUE(NI), .NUM_COMMIT(NC), .ROB_IDX_W(RW), .XLEN(XL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .commit_we(commit_we), .commit_rd_s(commit_rd_s), .commit_rd_v(commit_rd_v),
    .commit_rob(commit_rob), .issue_valid(issue_valid), .issue_opcode(issue_opcode),
    .issue_rd_s(issue_rd_s), .issue_rob(issue_rob), .issue_rs1_s(issue_rs1_s),
    .issue_rs2_s(issue_rs2_s), .issue_rs1_v(issue_rs1_v), .issue_rs2_v(issue_rs2_v),
    .issue_rs1_ready(issue_rs1_ready), .issue_rs2_ready(issue_rs2_ready),
    .issue_rs1_rob(issue_rs1_rob), .issue_rs2_rob(issue_rs2_rob),
    .sb_busy_cnt(sb_busy_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    bit            is_busy;
    int            slot;
    int            src;
    logic          ready;
    logic [RW-1:0] rob;
    logic [XL-1:0] v;
    bit            chk_rob;
    bit            chk_v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  event chk_ev;

  task automatic run_checks();
    exp_t          e;
    logic          a_rdy;
    logic [RW-1:0] a_rob;
    logic [XL-1:0] a_v;
    bit            ok;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (e.is_busy) begin
        if (sb_busy_cnt !== e.v[5:0]) begin
          failures++;
          $display("FAIL %s: sb_busy_cnt got %0d want %0d", e.name, sb_busy_cnt, e.v[5:0]);
        end
      end else begin
        a_rdy = (e.src == 1) ? issue_rs1_ready[e.slot] : issue_rs2_ready[e.slot];
        a_rob = (e.src == 1) ? issue_rs1_rob[e.slot]   : issue_rs2_rob[e.slot];
        a_v   = (e.src == 1) ? issue_rs1_v[e.slot]     : issue_rs2_v[e.slot];
        ok = (a_rdy === e.ready) && (!e.chk_rob || a_rob === e.rob) && (!e.chk_v || a_v === e.v);
        if (!ok) begin
          failures++;
          $display("FAIL %s: slot%0d rs%0d got ready=%b rob=%0d v=%h want ready=%b rob=%0d v=%h",
                   e.name, e.slot, e.src, a_rdy, a_rob, a_v, e.ready, e.rob, e.v);
        end
      end
    end
  endtask

  always @(negedge clk) run_checks();
  always @(chk_ev) run_checks();

  task automatic push(string n, bit b, int s, int src, logic r, logic [RW-1:0] rb,
                      logic [XL-1:0] v, bit cr, bit cv);
    exp_t e;
    e.name = n; e.is_busy = b; e.slot = s; e.src = src; e.ready = r;
    e.rob = rb; e.v = v; e.chk_rob = cr; e.chk_v = cv;
    exp_q.push_back(e);
  endtask

  task automatic exp_rdy(string n, int s, int src, logic [XL-1:0] v);
    push(n, 1'b0, s, src, 1'b1, '0, v, 1'b0, 1'b1);
  endtask
  task automatic exp_rdy0(string n, int s, int src, logic [XL-1:0] v);
    push(n, 1'b0, s, src, 1'b1, '0, v, 1'b1, 1'b1);
  endtask
  task automatic exp_pend(string n, int s, int src, logic [RW-1:0] rb);
    push(n, 1'b0, s, src, 1'b0, rb, '0, 1'b1, 1'b0);
  endtask
  task automatic exp_busy(string n, int cnt);
    push(n, 1'b1, 0, 0, 1'b0, '0, XL'(cnt), 1'b0, 1'b0);
  endtask

  task automatic clear_inputs();
    flush = 1'b0;
    commit_we = '0; commit_rd_s = '0; commit_rd_v = '0; commit_rob = '0;
    issue_valid = '0; issue_opcode = '0; issue_rd_s = '0; issue_rob = '0;
    issue_rs1_s = '0; issue_rs2_s = '0;
  endtask

  task automatic set_issue(int s, logic [6:0] op, logic [4:0] rd, logic [RW-1:0] rb);
    issue_valid[s] = 1'b1; issue_opcode[s] = op; issue_rd_s[s] = rd; issue_rob[s] = rb;
  endtask

  task automatic set_commit(int p, logic [4:0] rd, logic [XL-1:0] v, logic [RW-1:0] rb);
    commit_we[p] = 1'b1; commit_rd_s[p] = rd; commit_rd_v[p] = v; commit_rob[p] = rb;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    issue_rs1_s[0] = 5'd5; issue_rs2_s[0] = 5'd9; issue_rs1_s[1] = 5'd7;
    #3;
    exp_rdy0("rst_s0_rs1", 0, 1, 32'h0);
    exp_rdy0("rst_s0_rs2", 0, 2, 32'h0);
    exp_rdy0("rst_s1_rs1", 1, 1, 32'h0);
    exp_rdy0("rst_s1_rs2_x0", 1, 2, 32'h0);
    exp_busy("rst_busy", 0);
    -> chk_ev;
    #4;
    rst_n = 1'b1;
    clear_inputs();

    // x5 issued by slot0 with rob3, read by both slots in the same cycle
    set_issue(0, OP_ALU, 5'd5, 4'd3);
    issue_rs1_s[0] = 5'd5; issue_rs1_s[1] = 5'd5;
    exp_rdy("same_slot_own_rd", 0, 1, 32'h0);
    exp_pend("fwd_older_slot", 1, 1, 4'd3);
    exp_busy("busy_first", 0);
    next_cycle();
    issue_rs1_s[0] = 5'd5;
    exp_pend("x5_pending", 0, 1, 4'd3);
    exp_busy("busy_x5", 1);
    next_cycle();

    // matching commit bypass
    set_commit(0, 5'd5, 32'hDEAD, 4'd3);
    issue_rs1_s[0] = 5'd5; issue_rs2_s[1] = 5'd5;
    exp_rdy("commit_bypass_s0", 0, 1, 32'hDEAD);
    exp_rdy("commit_bypass_s1", 1, 2, 32'hDEAD);
    exp_busy("busy_at_commit", 1);
    next_cycle();
    issue_rs1_s[0] = 5'd5;
    exp_rdy("x5_from_reg", 0, 1, 32'hDEAD);
    exp_busy("busy_after_commit", 0);
    next_cycle();

    // stale-tag commit, plus two ports writing the same rd
    set_issue(0, OP_ALU, 5'd7, 4'd2);
    set_commit(0, 5'd10, 32'hAAAA, 4'd0);
    set_commit(1, 5'd10, 32'hBBBB, 4'd0);
    issue_rs1_s[1] = 5'd7;
    exp_pend("x7_fwd", 1, 1, 4'd2);
    exp_busy("busy_pre_x7", 0);
    next_cycle();
    set_commit(1, 5'd7, 32'h1234, 4'd1);
    issue_rs1_s[0] = 5'd7; issue_rs2_s[1] = 5'd10;
    exp_pend("stale_no_bypass", 0, 1, 4'd2);
    exp_rdy("port_priority", 1, 2, 32'hBBBB);
    exp_busy("busy_x7", 1);
    next_cycle();
    issue_rs1_s[0] = 5'd7;
    flush = 1'b1;
    exp_pend("x7_still_pend", 0, 1, 4'd2);
    exp_busy("busy_x7_kept", 1);
    next_cycle();
    issue_rs1_s[0] = 5'd7;
    exp_rdy("stale_commit_wrote_reg", 0, 1, 32'h1234);
    exp_busy("busy_after_flush1", 0);
    next_cycle();

    // commit clear and reissue of x9 in the same cycle
    set_issue(0, OP_ALU, 5'd9, 4'd5);
    exp_busy("busy_pre_x9", 0);
    next_cycle();
    set_commit(0, 5'd9, 32'h99, 4'd5);
    set_issue(1, OP_ALU, 5'd9, 4'd6);
    issue_rs1_s[0] = 5'd9;
    exp_rdy("x9_bypass", 0, 1, 32'h99);
    exp_busy("busy_x9", 1);
    next_cycle();
    issue_rs1_s[0] = 5'd9;
    exp_pend("issue_beats_clear", 0, 1, 4'd6);
    exp_busy("busy_unchanged", 1);
    next_cycle();

    // build four pending entries, non-writers in between, then flush
    set_issue(0, OP_ALU, 5'd12, 4'd7);
    set_issue(1, OP_ALU, 5'd12, 4'd8);
    exp_busy("busy_e1", 1);
    next_cycle();
    set_issue(0, OP_ST, 5'd13, 4'd1);
    set_issue(1, OP_ALU, 5'd14, 4'd9);
    issue_rs1_s[1] = 5'd13; issue_rs2_s[1] = 5'd12;
    exp_rdy("store_not_writer", 1, 1, 32'h0);
    exp_pend("x12_youngest_slot", 1, 2, 4'd8);
    exp_busy("busy_e2", 2);
    next_cycle();
    set_issue(0, OP_ALU, 5'd15, 4'd10);
    set_issue(1, OP_ALU, 5'd0, 4'd11);
    issue_rs1_s[1] = 5'd0; issue_rs2_s[1] = 5'd15;
    exp_rdy0("rs_x0", 1, 1, 32'h0);
    exp_pend("x15_fwd", 1, 2, 4'd10);
    exp_busy("busy_e3", 3);
    next_cycle();
    flush = 1'b1;
    set_issue(0, OP_ALU, 5'd16, 4'd12);
    issue_rs1_s[1] = 5'd16;
    exp_pend("x16_fwd_in_flush", 1, 1, 4'd12);
    exp_busy("busy_four", 4);
    next_cycle();
    set_issue(0, OP_BR, 5'd17, 4'd3);
    issue_rs1_s[0] = 5'd9; issue_rs2_s[0] = 5'd12;
    issue_rs1_s[1] = 5'd16; issue_rs2_s[1] = 5'd17;
    exp_rdy("flush_x9", 0, 1, 32'h99);
    exp_rdy("flush_x12", 0, 2, 32'h0);
    exp_rdy("flush_beats_issue", 1, 1, 32'h0);
    exp_rdy("branch_not_writer", 1, 2, 32'h0);
    exp_busy("busy_after_flush2", 0);
    next_cycle();

    // asynchronous reset in the middle of a cycle with entries pending
    set_issue(0, OP_ALU, 5'd20, 4'd4);
    set_issue(1, OP_ALU, 5'd21, 4'd5);
    exp_busy("busy_pre_f", 0);
    next_cycle();
    issue_rs1_s[0] = 5'd20; issue_rs1_s[1] = 5'd21; issue_rs2_s[1] = 5'd10;
    exp_pend("x20_pend", 0, 1, 4'd4);
    exp_pend("x21_pend", 1, 1, 4'd5);
    exp_rdy("x10_before_rst", 1, 2, 32'hBBBB);
    exp_busy("busy_two", 2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_rdy0("async_rst_x20", 0, 1, 32'h0);
    exp_rdy0("async_rst_x21", 1, 1, 32'h0);
    exp_rdy0("async_rst_x10", 1, 2, 32'h0);
    exp_busy("async_rst_busy", 0);
    -> chk_ev;
    #4;
    rst_n = 1'b1;
    next_cycle();
    next_cycle();
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations never compared, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
